// File: rtl/bcd_to_binary_seq_pkg.sv
// bcd_to_binary_seq_pkg: shared constants for the BCD <-> binary conversion paths.  Rev 1.0
`default_nettype none

package bcd_to_binary_seq_pkg;

  localparam int DEF_DIGITS = 5;
  localparam int DEF_BIN_W  = 16;
  localparam int DEF_ITERS  = 17;

  localparam logic [3:0] BCD_DIGIT_MAX   = 4'd9;
  localparam logic [3:0] BCD_CORR_THRESH = 4'd8;
  localparam logic [3:0] BCD_CORR_OFFSET = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d > BCD_DIGIT_MAX;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_to_binary_seq_digit_correct.sv
// bcd_digit_correct: reverse double-dabble digit fixup, subtracts 3 from digits >= 8.  Rev 1.0
`default_nettype none

module bcd_digit_correct
  import bcd_to_binary_seq_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= BCD_CORR_THRESH) ? (i_digit - BCD_CORR_OFFSET) : i_digit;

endmodule

`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential packed-BCD to binary converter (reverse double-dabble).  Rev 1.0
// Option: define BCD_TO_BINARY_SATURATE_EN to clamp overflowing results to all ones.
`default_nettype none

module bcd_to_binary_seq
  import bcd_to_binary_seq_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int BIN_W  = DEF_BIN_W,
  parameter int ITERS  = DEF_ITERS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done_tick,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  overflow,
  output logic                  invalid
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + ITERS;
  localparam int CNT_W  = $clog2(ITERS + 1);

  state_t               r_state;
  logic [WORK_W-1:0]    r_work;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_pend_inv;
  logic                 r_busy;
  logic                 r_done;
  logic [BIN_W-1:0]     r_bin;
  logic                 r_ovf;
  logic                 r_inv;

  logic [WORK_W-1:0]    w_shifted;
  logic [BCD_W-1:0]     w_bcd_corr;
  logic [WORK_W-1:0]    w_work_next;
  logic [DIGITS-1:0]    w_dig_bad;
  logic                 w_in_invalid;
  logic                 w_ovf;
  logic [BIN_W-1:0]     w_acc_bin;
  logic [BIN_W-1:0]     w_bin_res;

  assign w_shifted = r_work >> 1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_correct u_corr (
      .i_digit (w_shifted[ITERS + 4*gi +: 4]),
      .o_digit (w_bcd_corr[4*gi +: 4])
    );
    assign w_dig_bad[gi] = digit_invalid(bcd_in[4*gi +: 4]);
  end

  assign w_work_next  = {w_bcd_corr, w_shifted[ITERS-1:0]};
  assign w_in_invalid = |w_dig_bad;

  // The accumulator holds the finished binary value in its low ITERS bits.
  if (ITERS > BIN_W) begin : g_acc_wide
    assign w_ovf     = |r_work[ITERS-1:BIN_W];
    assign w_acc_bin = r_work[BIN_W-1:0];
  end else begin : g_acc_narrow
    assign w_ovf     = 1'b0;
    assign w_acc_bin = BIN_W'(r_work[ITERS-1:0]);
  end

`ifdef BCD_TO_BINARY_SATURATE_EN
  assign w_bin_res = w_ovf ? {BIN_W{1'b1}} : w_acc_bin;
`else
  assign w_bin_res = w_acc_bin;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_work     <= '0;
      r_cnt      <= '0;
      r_pend_inv <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bin      <= '0;
      r_ovf      <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      // busy trails the state by one cycle so it covers the done_tick cycle.
      r_busy <= (r_state != ST_IDLE);
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ovf <= 1'b0;
            r_inv <= 1'b0;
            r_cnt <= '0;
            if (w_in_invalid) begin
              r_pend_inv <= 1'b1;
              r_work     <= '0;
              r_state    <= ST_DONE;
            end else begin
              r_pend_inv <= 1'b0;
              r_work     <= {bcd_in, {ITERS{1'b0}}};
              r_state    <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_work_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(ITERS - 1)) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_inv   <= r_pend_inv;
          r_bin   <= r_pend_inv ? '0 : w_bin_res;
          r_ovf   <= r_pend_inv ? 1'b0 : w_ovf;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done_tick = r_done;
  assign bin_out   = r_bin;
  assign overflow  = r_ovf;
  assign invalid   = r_inv;

endmodule

`default_nettype wire

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the 16-bit binary-to-BCD decode path.
- Converts a 5-digit packed BCD value, such as an operator-entered preset for the arithmetic accumulator, into a 16-bit binary value.
- Uses reverse double-dabble: one right-shift plus per-digit correction per clock.
- Start/done handshake. Sits between the keypad/BCD entry logic and the arithmetic register load path.

Parameters:
- DIGITS, 5, number of packed BCD digits on bcd_in (width 4*DIGITS).
- BIN_W, 16, width of bin_out.
- ITERS, 17, shift iterations; must be >= bit length of (10^DIGITS - 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- bcd_in  in  4*DIGITS  packed BCD, digit 0 in [3:0]; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done_tick.
- done_tick  out  1  one-cycle pulse; result outputs valid from this cycle.
- bin_out  out  BIN_W  converted value; held until the next accepted start.
- overflow  out  1  value > 2^BIN_W - 1; held with bin_out.
- invalid  out  1  some input digit > 9; held with bin_out.

Behaviour:
- Reset: on rst=0 at a clock edge:
  - State goes to IDLE.
  - busy=0, done_tick=0, bin_out=0, overflow=0, invalid=0.
  - Internal shift register and iteration counter are cleared.
  - Reset mid-conversion aborts the conversion; no done_tick is emitted.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, latch bcd_in and clear overflow/invalid.
  - If any digit > 9, go to DONE with invalid=1 and result 0.
  - Otherwise load the work register {bcd[4*DIGITS-1:0], acc[ITERS-1:0]=0}, set count=0, and go to SHIFT.
- SHIFT, each cycle:
  - Shift {bcd, acc} right by 1; bcd LSB enters acc MSB.
  - In the same cycle, each shifted BCD digit >= 8 has 3 subtracted.
  - Increment count; after iteration ITERS go to DONE.
  - start is ignored while in SHIFT.
- DONE, for one cycle:
  - Assert done_tick.
  - Register bin_out and overflow from acc. overflow = |acc[ITERS-1:BIN_W].
  - Return to IDLE.
- Latency for valid input: start accepted at edge N; busy high N+1..N+ITERS+1; done_tick at cycle N+ITERS+1 (N+18 with defaults).
- Latency for invalid input: done_tick at N+1; bin_out=0, overflow=0.
- start held high continuously: a new conversion is accepted on the IDLE cycle following DONE.
- Outputs are stable between done_tick pulses; they never show intermediate values.

Optional Feature:
- Macro: BCD_TO_BINARY_SATURATE_EN.
- Defined: on overflow, bin_out = all ones (16'hFFFF); overflow=1.
- Undefined: on overflow, bin_out = acc[BIN_W-1:0] (truncated); overflow=1.
- In both builds, invalid input forces bin_out=0.

Decomposition:
- Shared package holds:
  - State encoding constants ST_IDLE, ST_SHIFT, ST_DONE.
  - BCD_DIGIT_MAX=9.
  - BCD correction threshold 8 and offset 3.
  - Default DIGITS/BIN_W/ITERS values, shared with the binary-to-BCD decode path.
- One natural sub-module: bcd_digit_correct.
  - Combinational, 4-bit in/out: out = (in >= 8) ? in - 3 : in.
  - Instantiated DIGITS times via generate.

Test Plan:
- start with bcd_in=20'h12345 -> done_tick exactly 18 cycles later; bin_out=16'h3039, overflow=0, invalid=0; busy high for cycles 1..18.
- bcd_in=20'h65535, then bcd_in=20'h00000 -> bin_out=16'hFFFF then 16'h0000; overflow=0 for both.
- bcd_in=20'h99999 -> overflow=1.
  - With BCD_TO_BINARY_SATURATE_EN: bin_out=16'hFFFF.
  - Without it: bin_out=16'h869F.
- bcd_in=20'h0001A -> done_tick 1 cycle after start; invalid=1, bin_out=0, overflow=0.
- Second start pulse with bcd_in=20'h00001 during SHIFT of a 20'h00042 conversion -> ignored; single done_tick with bin_out=16'h002A.
- rst=0 at cycle 8 of a 20'h12345 conversion -> next cycle all outputs 0, no done_tick; a subsequent start with 20'h00100 yields bin_out=16'h0064.
